sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo.sv | 109 ++++++++++
 tb/tb_sync_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo: single-clock first-in first-out buffer with registered read data.
//
// Parameters
//   DEPTH       number of entries (power of two, >= 2)
//   DATA_WIDTH  bits per entry
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous reset, active low
//   write_en  write request; accepted when not full
//   read_en   read request; accepted when not empty
//   data_in   write data captured with an accepted write
//   data_out  registered read data; holds until the next accepted read
//   full      FIFO holds DEPTH entries
//   empty     FIFO holds no entries
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // Elaboration-time guard on the geometry the pointer arithmetic relies on.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_data_out;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;

    // Flags decode only registered state, so there is no input-to-flag path.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == CW'(0));

    // Full blocks writes and empty blocks reads, so a simultaneous request
    // on an empty FIFO is write-only and on a full FIFO is read-only.
    assign w_wr_acc = write_en & ~w_full;
    assign w_rd_acc = read_en  & ~w_empty;

    // Storage is deliberately not reset; the zeroed count keeps stale
    // entries from ever being read.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy moves only when exactly one side is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Read data is registered and valid right after the accepting edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_out <= '0;
        end else if (w_rd_acc) begin
            r_data_out <= r_mem[r_rd_ptr];
        end
    end

    assign data_out = r_data_out;
    assign full     = w_full;
    assign empty    = w_empty;

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo: scoreboard bench for sync_fifo (DEPTH=8, DATA_WIDTH=16).
// Accepted writes push to a queue; accepted reads pop the expected word.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = 16;

    logic          clk;
    logic          rst;
    logic          write_en;
    logic          read_en;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;

    sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .write_en (write_en),
        .read_en  (read_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] sb_q[$];
    int            m_count  = 0;
    logic [DW-1:0] m_dout   = '0;

    // One clock of stimulus; updates the reference model from pre-edge state.
    task automatic step(input logic wr, input logic rd, input logic [DW-1:0] d);
        logic wa;
        logic ra;
        @(negedge clk);
        write_en = wr;
        read_en  = rd;
        data_in  = d;
        wa = wr && (m_count < int'(DEPTH));
        ra = rd && (m_count > 0);
        @(posedge clk);
        #1;
        if (ra) m_dout = sb_q.pop_front();
        if (wa) sb_q.push_back(d);
        if (wa && !ra) m_count++;
        if (ra && !wa) m_count--;
        write_en = 1'b0;
        read_en  = 1'b0;
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_count = 0;
        m_dout  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0; write_en = 1'b0; read_en = 1'b0; data_in = '0;
        model_reset();
        #23;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: empty=%b full=%b, required empty=1 full=0", empty, full);
        end
        checks++;
        if (data_out !== 16'h0000) begin
            failures++;
            $display("FAIL reset_dout: got %h, required 0000", data_out);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 16'(16'h1111 * (i + 1)));
            checks++;
            if (full !== (m_count == int'(DEPTH)) || empty !== (m_count == 0)) begin
                failures++;
                $display("FAIL fill_flags[%0d]: full=%b empty=%b, required count=%0d", i, full, empty, m_count);
            end
        end
        checks++;
        if (full !== 1'b1 || empty !== 1'b0) begin
            failures++;
            $display("FAIL fill_full: full=%b empty=%b, required full=1 empty=0", full, empty);
        end
    endtask

    task automatic test_full_write();
        step(1'b1, 1'b0, 16'hBEEF);
        checks++;
        if (full !== 1'b1 || m_count != int'(DEPTH)) begin
            failures++;
            $display("FAIL full_write_ignored: full=%b, required 1", full);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, '0);
            checks++;
            if (data_out !== m_dout || data_out !== 16'(16'h1111 * (i + 1))) begin
                failures++;
                $display("FAIL drain_data[%0d]: got %h, required %h", i, data_out, m_dout);
            end
        end
        checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty: empty=%b full=%b, required empty=1 full=0", empty, full);
        end
    endtask

    task automatic test_empty_read();
        step(1'b0, 1'b1, '0);
        checks++;
        if (data_out !== 16'h8888 || empty !== 1'b1) begin
            failures++;
            $display("FAIL empty_read_hold: dout=%h empty=%b, required 8888 empty=1", data_out, empty);
        end
        // simultaneous on empty: write only, output unchanged
        step(1'b1, 1'b1, 16'h4242);
        checks++;
        if (data_out !== 16'h8888 || empty !== 1'b0 || dut.r_count !== 4'd1) begin
            failures++;
            $display("FAIL empty_rw: dout=%h empty=%b count=%0d, required 8888 0 1", data_out, empty, dut.r_count);
        end
        // pointers were not disturbed by the rejected read
        step(1'b0, 1'b1, '0);
        checks++;
        if (data_out !== m_dout || data_out !== 16'h4242) begin
            failures++;
            $display("FAIL empty_read_ptr: got %h, required 4242", data_out);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'(16'hA000 + i));
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, '0);
            checks++;
            if (data_out !== m_dout) begin
                failures++;
                $display("FAIL wrap_read_a[%0d]: got %h, required %h", i, data_out, m_dout);
            end
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'(16'hB000 + i));
        checks++;
        if (full !== 1'b1) begin
            failures++;
            $display("FAIL wrap_full: full=%b, required 1", full);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, '0);
            checks++;
            if (data_out !== m_dout) begin
                failures++;
                $display("FAIL wrap_read_b[%0d]: got %h, required %h", i, data_out, m_dout);
            end
        end
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL wrap_empty: empty=%b, required 1", empty);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 16'(16'hC000 + i));
        step(1'b1, 1'b1, 16'hC004);
        checks++;
        if (data_out !== 16'hC001 || dut.r_count !== 4'd3) begin
            failures++;
            $display("FAIL simul_mid: dout=%h count=%0d, required C001 3", data_out, dut.r_count);
        end
        for (int i = 5; i <= 9; i++) step(1'b1, 1'b0, 16'(16'hC000 + i));
        // simultaneous on full: read only, incoming word dropped
        step(1'b1, 1'b1, 16'hDEAD);
        checks++;
        if (data_out !== 16'hC002 || full !== 1'b0 || dut.r_count !== 4'd7) begin
            failures++;
            $display("FAIL simul_full: dout=%h full=%b count=%0d, required C002 0 7", data_out, full, dut.r_count);
        end
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, '0);
            checks++;
            if (data_out !== m_dout || data_out === 16'hDEAD) begin
                failures++;
                $display("FAIL simul_drain[%0d]: got %h, required %h", i, data_out, m_dout);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, 16'h5151);
        step(1'b1, 1'b0, 16'h5252);
        step(1'b0, 1'b1, '0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || data_out !== 16'h0000) begin
            failures++;
            $display("FAIL reset_mid: empty=%b full=%b dout=%h, required 1 0 0000", empty, full, data_out);
        end
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b0, 16'h7777);
        step(1'b0, 1'b1, '0);
        checks++;
        if (data_out !== m_dout || data_out !== 16'h7777) begin
            failures++;
            $display("FAIL reset_first_read: got %h, required 7777", data_out);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_write();
        test_drain();
        test_empty_read();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
